mult_operand_feeder: RTL and testbench

- Upstream stage of fifomult2024.
- Accepts signed 16-bit operand pairs {A,B} from a producer over a valid/ready handshake and buffers them in a small pair FIFO.
- Computes even-parity bits for each operand, with optional per-operand error injection.
- Serialises each pair as two single-cycle data_in_valid pulses (A then B), gated by the multiplier's busy_out.

---
 rtl/mult_operand_feeder.sv | 219 +++++++++++++++++++++
 tb/tb_mult_operand_feeder.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder
// Upstream stage of fifomult2024. Buffers signed 16-bit operand pairs {A,B}
// from a valid/ready producer in a small pair FIFO. Each pair is then sent to
// the multiplier as two single-cycle data_in_valid pulses (A, then B). Each
// pulse carries an even-parity bit, which can be deliberately corrupted per
// operand. Pulses are issued only while the multiplier reports not busy.
//
// Ports:
//   clk, rst_n                  clock (posedge) and async active-low reset
//   op_a, op_b                  operand pair offered by the producer
//   op_inject_a, op_inject_b    invert the generated parity of A / B
//   op_valid / op_ready         producer handshake (op_ready = !full)
//   mult_busy                   fifomult2024 busy_out
//   mult_data_in[_parity|_valid] operand, parity and strobe to fifomult2024
//   fifo_level                  number of pairs currently stored
//   pairs_sent                  pairs fully issued (wrapping 16-bit count)
module mult_operand_feeder #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [15:0]                op_a,
    input  logic [15:0]                op_b,
    input  logic                       op_inject_a,
    input  logic                       op_inject_b,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic                       mult_busy,
    output logic [15:0]                mult_data_in,
    output logic                       mult_data_in_parity,
    output logic                       mult_data_in_valid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [15:0]                pairs_sent
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = AW + 1;
    localparam int ENTRY_W = 34;
    localparam int GW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT_A = 3'd1,
        ST_SEND_A = 3'd2,
        ST_GAP_A  = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_SEND_B = 3'd5,
        ST_GAP_B  = 3'd6
    } state_t;

    // Even parity over an operand, optionally inverted for error injection.
    function automatic logic even_parity(input logic [15:0] value, input logic inject);
        return (^value) ^ inject;
    endfunction

    // Entry layout: {A[33:18], B[17:2], inject_a[1], inject_b[0]}
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [ENTRY_W-1:0] hold_r;
    logic [GW-1:0]      gap_cnt_r;
    state_t             state_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    state_t             state_next_s;
    logic [GW-1:0]      gap_next_s;
    logic               valid_next_s;
    logic [15:0]        data_next_s;
    logic               par_next_s;
    logic               sent_inc_s;

    logic [15:0]        hold_a_s;
    logic [15:0]        hold_b_s;
    logic               hold_inj_a_s;
    logic               hold_inj_b_s;

    assign hold_a_s     = hold_r[33:18];
    assign hold_b_s     = hold_r[17:2];
    assign hold_inj_a_s = hold_r[1];
    assign hold_inj_b_s = hold_r[0];

    // Full/empty come from the level counter, so the pointers can wrap freely.
    assign full_s   = (fifo_level == LW'(DEPTH));
    assign empty_s  = (fifo_level == {LW{1'b0}});
    assign op_ready = !full_s;
    // A full FIFO refuses a push even if the FSM pops in the same cycle.
    assign push_s   = op_valid && !full_s;

    // FIFO storage write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= {op_a, op_b, op_inject_a, op_inject_b};
        end
    end

    // FIFO pointers, level, and the holding register loaded on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            fifo_level <= {LW{1'b0}};
            hold_r     <= {ENTRY_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                hold_r   <= mem_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // FSM state, gap counter and registered multiplier-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r             <= ST_IDLE;
            gap_cnt_r           <= {GW{1'b0}};
            mult_data_in        <= 16'd0;
            mult_data_in_parity <= 1'b0;
            mult_data_in_valid  <= 1'b0;
            pairs_sent          <= 16'd0;
        end else begin
            state_r             <= state_next_s;
            gap_cnt_r           <= gap_next_s;
            mult_data_in        <= data_next_s;
            mult_data_in_parity <= par_next_s;
            mult_data_in_valid  <= valid_next_s;
            if (sent_inc_s) begin
                pairs_sent <= pairs_sent + 16'd1;
            end
        end
    end

    // FSM next-state and next-output logic. Data/parity default to holding.
    always_comb begin
        state_next_s = state_r;
        gap_next_s   = gap_cnt_r;
        pop_s        = 1'b0;
        valid_next_s = 1'b0;
        data_next_s  = mult_data_in;
        par_next_s   = mult_data_in_parity;
        sent_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_WAIT_A;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT_A: begin
                if (!mult_busy) begin
                    state_next_s = ST_SEND_A;
                    valid_next_s = 1'b1;
                    data_next_s  = hold_a_s;
                    par_next_s   = even_parity(hold_a_s, hold_inj_a_s);
                end else begin
                    state_next_s = ST_WAIT_A;
                end
            end
            ST_SEND_A: begin
                state_next_s = ST_GAP_A;
                gap_next_s   = {GW{1'b0}};
            end
            ST_GAP_A: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_next_s = ST_WAIT_B;
                    gap_next_s   = {GW{1'b0}};
                end else begin
                    gap_next_s   = gap_cnt_r + GW'(1);
                end
            end
            ST_WAIT_B: begin
                if (!mult_busy) begin
                    state_next_s = ST_SEND_B;
                    valid_next_s = 1'b1;
                    data_next_s  = hold_b_s;
                    par_next_s   = even_parity(hold_b_s, hold_inj_b_s);
                    sent_inc_s   = 1'b1;
                end else begin
                    state_next_s = ST_WAIT_B;
                end
            end
            ST_SEND_B: begin
                state_next_s = ST_GAP_B;
                gap_next_s   = {GW{1'b0}};
            end
            ST_GAP_B: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_next_s = ST_IDLE;
                    gap_next_s   = {GW{1'b0}};
                end else begin
                    gap_next_s   = gap_cnt_r + GW'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                gap_next_s   = {GW{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Self-checking bench for mult_operand_feeder (DEPTH=4, GAP_CYCLES=1).
// Inputs change on negedges; outputs are read on negedges. A monitor logs
// every valid pulse as {data, parity}, sampling 2 time units after each
// posedge.
module tb_mult_operand_feeder;

    logic        clk;
    logic        rst_n;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_inject_a;
    logic        op_inject_b;
    logic        op_valid;
    logic        op_ready;
    logic        mult_busy;
    logic [15:0] mult_data_in;
    logic        mult_data_in_parity;
    logic        mult_data_in_valid;
    logic [2:0]  fifo_level;
    logic [15:0] pairs_sent;

    int checks;
    int failures;
    logic [16:0] pulses [$];

    mult_operand_feeder #(.DEPTH(4), .GAP_CYCLES(1)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .op_a                (op_a),
        .op_b                (op_b),
        .op_inject_a         (op_inject_a),
        .op_inject_b         (op_inject_b),
        .op_valid            (op_valid),
        .op_ready            (op_ready),
        .mult_busy           (mult_busy),
        .mult_data_in        (mult_data_in),
        .mult_data_in_parity (mult_data_in_parity),
        .mult_data_in_valid  (mult_data_in_valid),
        .fifo_level          (fifo_level),
        .pairs_sent          (pairs_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor.
    always @(posedge clk) begin
        #2;
        if (rst_n && mult_data_in_valid) pulses.push_back({mult_data_in, mult_data_in_parity});
    end

    // Offer a pair starting at the current negedge; return at the negedge after acceptance.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b, input logic ia, input logic ib);
        logic acc;
        int   budget;
        op_a = a; op_b = b; op_inject_a = ia; op_inject_b = ib; op_valid = 1'b1;
        budget = 0;
        acc = 1'b0;
        while (!acc && budget < 100) begin
            acc = op_ready;
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL push_accept: pair a=%h never accepted within budget", a);
        end
    endtask

    task automatic wait_pulses(input int n, input int max_cycles);
        int c;
        c = 0;
        while (pulses.size() < n && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; op_valid = 1'b0; op_a = 16'd0; op_b = 16'd0;
        op_inject_a = 1'b0; op_inject_b = 1'b0; mult_busy = 1'b0;
        #1;
        checks++;
        if (mult_data_in_valid !== 1'b0 || mult_data_in !== 16'd0 || mult_data_in_parity !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b data=%h par=%b required 0/0000/0",
                     mult_data_in_valid, mult_data_in, mult_data_in_parity);
        end
        checks++;
        if (fifo_level !== 3'd0 || pairs_sent !== 16'd0) begin
            failures++;
            $display("FAIL reset_counts: level=%0d sent=%0d required 0/0", fifo_level, pairs_sent);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (op_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: op_ready=%b required 1", op_ready);
        end
    endtask

    task automatic test_single_pair;
        pulses.delete();
        push_pair(16'd3, 16'd5, 1'b0, 1'b0);
        op_valid = 1'b0;
        checks++;
        if (fifo_level !== 3'd1) begin
            failures++; $display("FAIL single_level_push: level=%0d required 1", fifo_level);
        end
        @(negedge clk); // after N+1: popped, WAIT_A
        checks++;
        if (fifo_level !== 3'd0 || mult_data_in_valid !== 1'b0) begin
            failures++; $display("FAIL single_pop: level=%0d valid=%b required 0/0", fifo_level, mult_data_in_valid);
        end
        @(negedge clk); // after N+2: A pulse
        checks++;
        if (mult_data_in_valid !== 1'b1 || mult_data_in !== 16'd3 || mult_data_in_parity !== 1'b0) begin
            failures++; $display("FAIL single_a: valid=%b data=%h par=%b required 1/0003/0",
                                 mult_data_in_valid, mult_data_in, mult_data_in_parity);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); // GAP_A, WAIT_B
            checks++;
            if (mult_data_in_valid !== 1'b0 || mult_data_in !== 16'd3) begin
                failures++; $display("FAIL single_gap%0d: valid=%b data=%h required 0/0003", i, mult_data_in_valid, mult_data_in);
            end
        end
        @(negedge clk); // after N+5: B pulse
        checks++;
        if (mult_data_in_valid !== 1'b1 || mult_data_in !== 16'd5 || mult_data_in_parity !== 1'b0 || pairs_sent !== 16'd1) begin
            failures++; $display("FAIL single_b: valid=%b data=%h par=%b sent=%0d required 1/0005/0/1",
                                 mult_data_in_valid, mult_data_in, mult_data_in_parity, pairs_sent);
        end
        @(negedge clk);
        checks++;
        if (mult_data_in_valid !== 1'b0 || mult_data_in !== 16'd5) begin
            failures++; $display("FAIL single_after_b: valid=%b data=%h required 0/0005", mult_data_in_valid, mult_data_in);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (pulses.size() != 2 || fifo_level !== 3'd0) begin
            failures++; $display("FAIL single_count: pulses=%0d level=%0d required 2/0", pulses.size(), fifo_level);
        end
    endtask

    task automatic test_parity_inject;
        logic [16:0] exp_q [$];
        pulses.delete();
        exp_q = '{ {16'h0001, 1'b1}, {16'h8000, 1'b1},
                   {16'h0001, 1'b0}, {16'h8000, 1'b1},
                   {16'h7FFF, 1'b1}, {16'hFFFF, 1'b0},
                   {16'h7FFF, 1'b1}, {16'hFFFF, 1'b1} };
        push_pair(16'h0001, 16'h8000, 1'b0, 1'b0);
        push_pair(16'h0001, 16'h8000, 1'b1, 1'b0);
        push_pair(16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
        push_pair(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
        op_valid = 1'b0; op_inject_a = 1'b0; op_inject_b = 1'b0;
        wait_pulses(8, 80);
        checks++;
        if (pulses.size() != 8) begin
            failures++; $display("FAIL parity_count: pulses=%0d required 8", pulses.size());
        end
        for (int i = 0; i < 8; i++) begin
            if (i < pulses.size()) begin
                checks++;
                if (pulses[i] !== exp_q[i]) begin
                    failures++; $display("FAIL parity_pulse%0d: data=%h par=%b required %h/%b",
                                         i, pulses[i][16:1], pulses[i][0], exp_q[i][16:1], exp_q[i][0]);
                end
            end
        end
        checks++;
        if (pairs_sent !== 16'd5) begin
            failures++; $display("FAIL parity_sent: sent=%0d required 5", pairs_sent);
        end
    endtask

    task automatic test_busy_stall;
        pulses.delete();
        push_pair(16'h1234, 16'h00FF, 1'b0, 1'b0);
        op_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (mult_data_in_valid !== 1'b1 || mult_data_in !== 16'h1234 || mult_data_in_parity !== 1'b1) begin
            failures++; $display("FAIL stall_a: valid=%b data=%h par=%b required 1/1234/1",
                                 mult_data_in_valid, mult_data_in, mult_data_in_parity);
        end
        @(negedge clk); // GAP_A
        mult_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (mult_data_in_valid !== 1'b0 || mult_data_in !== 16'h1234) begin
                failures++; $display("FAIL stall_hold%0d: valid=%b data=%h required 0/1234", i, mult_data_in_valid, mult_data_in);
            end
        end
        mult_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (mult_data_in_valid !== 1'b1 || mult_data_in !== 16'h00FF || mult_data_in_parity !== 1'b0) begin
            failures++; $display("FAIL stall_b: valid=%b data=%h par=%b required 1/00FF/0",
                                 mult_data_in_valid, mult_data_in, mult_data_in_parity);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (pulses.size() != 2 || pairs_sent !== 16'd6) begin
            failures++; $display("FAIL stall_count: pulses=%0d sent=%0d required 2/6", pulses.size(), pairs_sent);
        end
    endtask

    task automatic test_full_backpressure;
        logic [16:0] exp_q [$];
        pulses.delete();
        exp_q = '{ {16'h0001, 1'b1}, {16'h0011, 1'b0},
                   {16'h0002, 1'b1}, {16'h0012, 1'b0},
                   {16'h0003, 1'b0}, {16'h0013, 1'b1},
                   {16'h0004, 1'b1}, {16'h0014, 1'b0},
                   {16'h0005, 1'b0}, {16'h0015, 1'b1} };
        mult_busy = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push_pair(16'(k), 16'(k + 16), 1'b0, 1'b0);
        end
        // Offer a sixth pair while full; it must be refused.
        op_a = 16'h0006; op_b = 16'h0016;
        checks++;
        if (fifo_level !== 3'd4 || op_ready !== 1'b0) begin
            failures++; $display("FAIL full_flag: level=%0d ready=%b required 4/0", fifo_level, op_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fifo_level !== 3'd4 || mult_data_in_valid !== 1'b0) begin
            failures++; $display("FAIL full_hold: level=%0d valid=%b required 4/0", fifo_level, mult_data_in_valid);
        end
        op_valid = 1'b0;
        mult_busy = 1'b0;
        wait_pulses(10, 100);
        checks++;
        if (pulses.size() != 10) begin
            failures++; $display("FAIL full_count: pulses=%0d required 10", pulses.size());
        end
        for (int i = 0; i < 10; i++) begin
            if (i < pulses.size()) begin
                checks++;
                if (pulses[i] !== exp_q[i]) begin
                    failures++; $display("FAIL full_pulse%0d: data=%h par=%b required %h/%b",
                                         i, pulses[i][16:1], pulses[i][0], exp_q[i][16:1], exp_q[i][0]);
                end
            end
        end
        checks++;
        if (pairs_sent !== 16'd11 || fifo_level !== 3'd0 || op_ready !== 1'b1) begin
            failures++; $display("FAIL full_end: sent=%0d level=%0d ready=%b required 11/0/1", pairs_sent, fifo_level, op_ready);
        end
    endtask

    task automatic test_reset_mid_pair;
        pulses.delete();
        push_pair(16'h0AAA, 16'h0555, 1'b0, 1'b0);
        push_pair(16'h0BBB, 16'h0666, 1'b0, 1'b0);
        op_valid = 1'b0;
        @(negedge clk); // A pulse of first pair
        checks++;
        if (mult_data_in_valid !== 1'b1 || mult_data_in !== 16'h0AAA) begin
            failures++; $display("FAIL rst_pre_a: valid=%b data=%h required 1/0AAA", mult_data_in_valid, mult_data_in);
        end
        @(negedge clk); // GAP_A
        checks++;
        if (fifo_level !== 3'd1) begin
            failures++; $display("FAIL rst_pre_level: level=%0d required 1", fifo_level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mult_data_in_valid !== 1'b0 || fifo_level !== 3'd0 || pairs_sent !== 16'd0 || mult_data_in !== 16'd0) begin
            failures++; $display("FAIL rst_async: valid=%b level=%0d sent=%0d data=%h required 0/0/0/0000",
                                 mult_data_in_valid, fifo_level, pairs_sent, mult_data_in);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses.delete();
        repeat (20) @(negedge clk);
        checks++;
        if (pulses.size() != 0 || pairs_sent !== 16'd0) begin
            failures++; $display("FAIL rst_no_b: pulses=%0d sent=%0d required 0/0", pulses.size(), pairs_sent);
        end
        push_pair(16'd7, 16'hFFFE, 1'b0, 1'b0);
        op_valid = 1'b0;
        wait_pulses(2, 30);
        checks++;
        if (pulses.size() != 2) begin
            failures++; $display("FAIL rst_next_count: pulses=%0d required 2", pulses.size());
        end else begin
            checks++;
            if (pulses[0] !== {16'h0007, 1'b1} || pulses[1] !== {16'hFFFE, 1'b1}) begin
                failures++; $display("FAIL rst_next_data: a=%h/%b b=%h/%b required 0007/1 FFFE/1",
                                     pulses[0][16:1], pulses[0][0], pulses[1][16:1], pulses[1][0]);
            end
        end
        checks++;
        if (pairs_sent !== 16'd1) begin
            failures++; $display("FAIL rst_next_sent: sent=%0d required 1", pairs_sent);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_pair();
        test_parity_inject();
        test_busy_stall();
        test_full_backpressure();
        test_reset_mid_pair();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
